// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for the MIPS execute stage; result = {remainder, quotient} for HI/LO.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the iterations and completes on the next cycle.
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   opdata1,
    input  logic [WIDTH-1:0]   opdata2,
    input  logic               annul,
    output logic               busy,
    output logic               ready,
    output logic [2*WIDTH-1:0] result
);

    typedef enum logic [1:0] {ST_IDLE, ST_DIV, ST_DONE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_dvs;
    logic [WIDTH-1:0]   r_op1;
    logic               r_sign1;
    logic               r_sign2;
    logic               r_dvz;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_result;

    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_trial;
    logic [WIDTH-1:0]   w_rem_nxt;
    logic [WIDTH-1:0]   w_quo_nxt;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [2*WIDTH-1:0] w_final;
    logic               w_last;
    logic               w_zero_in;

    function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] x);
        return (~x) + WIDTH'(1);
    endfunction

    function automatic logic [WIDTH-1:0] f_abs(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? f_neg(x) : x;
    endfunction

    // The dividend shifts out of r_quo into the partial remainder while quotient bits shift in.
    assign w_shift   = {r_rem, r_quo[WIDTH-1]};
    assign w_trial   = w_shift - {1'b0, r_dvs};
    assign w_rem_nxt = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign w_quo_nxt = {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
    assign w_rem_fix = r_sign1 ? f_neg(w_rem_nxt) : w_rem_nxt;
    assign w_quo_fix = (r_sign1 ^ r_sign2) ? f_neg(w_quo_nxt) : w_quo_nxt;
    // Divide by zero reports the raw dividend, bypassing any sign fix-up.
    assign w_final   = r_dvz ? {r_op1, {WIDTH{1'b1}}} : {w_rem_fix, w_quo_fix};
    assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_zero_in = (opdata2 == '0);

    assign busy   = (r_state == ST_DIV);
    assign ready  = (r_state == ST_DONE);
    assign result = r_result;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
`ifdef DIV_ZERO_FAST_EN
                    w_state_nxt = w_zero_in ? ST_DONE : ST_DIV;
`else
                    w_state_nxt = ST_DIV;
`endif
                end
            end
            ST_DIV: begin
                if (annul) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvs    <= '0;
            r_op1    <= '0;
            r_sign1  <= 1'b0;
            r_sign2  <= 1'b0;
            r_dvz    <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_op1   <= opdata1;
                        r_dvz   <= w_zero_in;
                        r_sign1 <= signed_div & opdata1[WIDTH-1];
                        r_sign2 <= signed_div & opdata2[WIDTH-1];
                        r_quo   <= signed_div ? f_abs(opdata1) : opdata1;
                        r_dvs   <= signed_div ? f_abs(opdata2) : opdata2;
                        r_rem   <= '0;
                        r_cnt   <= '0;
`ifdef DIV_ZERO_FAST_EN
                        if (w_zero_in) begin
                            r_result <= {opdata1, {WIDTH{1'b1}}};
                        end
`endif
                    end
                end
                ST_DIV: begin
                    if (!annul) begin
                        r_rem <= w_rem_nxt;
                        r_quo <= w_quo_nxt;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_last) begin
                            r_result <= w_final;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: cycle-level reference model plus directed vectors with literal results.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        annul;
    logic        busy;
    logic        ready;
    logic [63:0] result;

    int pass_cnt  = 0;
    int total_cnt = 0;

`ifdef DIV_ZERO_FAST_EN
    localparam int ZLAT = 1;
    localparam bit FAST = 1'b1;
`else
    localparam int ZLAT = 33;
    localparam bit FAST = 1'b0;
`endif

    div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .annul      (annul),
        .busy       (busy),
        .ready      (ready),
        .result     (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Architectural result from plain integer arithmetic.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    // Reference model: a divide in flight has a number of edges left until ready.
    bit          m_active = 1'b0;
    int          m_left   = 0;
    logic [63:0] m_val    = '0;
    bit          e_ready  = 1'b0;
    logic [63:0] e_result = '0;
    bit          prev_ready;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                m_active = 1'b0;
                m_left   = 0;
                e_ready  = 1'b0;
                e_result = '0;
            end else begin
                prev_ready = e_ready;
                e_ready    = 1'b0;
                if (m_active) begin
                    if (annul) begin
                        m_active = 1'b0;
                    end else begin
                        m_left--;
                        if (m_left == 0) begin
                            m_active = 1'b0;
                            e_ready  = 1'b1;
                            e_result = m_val;
                        end
                    end
                end else if (!prev_ready && start) begin
                    m_val = model(opdata1, opdata2, signed_div);
                    if (FAST && opdata2 == 32'd0) begin
                        e_ready  = 1'b1;
                        e_result = m_val;
                    end else begin
                        m_active = 1'b1;
                        m_left   = 32;
                    end
                end
            end
            chk("cyc_busy", {63'd0, busy}, {63'd0, m_active});
            chk("cyc_ready", {63'd0, ready}, {63'd0, e_ready});
            chk("cyc_result", result, e_result);
        end
    end

    task automatic run(input string name, input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [63:0] exp_res, input int exp_lat);
        int n;
        @(negedge clk); #1;
        opdata1 = a; opdata2 = b; signed_div = s; start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        n = 1;
        while (!ready && n < 80) begin
            @(negedge clk); #1;
            n++;
        end
        chk({name, "_lat"}, 64'(n), 64'(exp_lat));
        chk({name, "_res"}, result, exp_res);
    endtask

    initial begin
        int n;
        logic [63:0] held;
        rst = 1'b1; start = 1'b0; signed_div = 1'b0; annul = 1'b0;
        opdata1 = '0; opdata2 = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_ready", {63'd0, ready}, 64'd0);
        chk("rst_result", result, 64'd0);
        rst = 1'b0;

        chk("model_u", model(32'd100, 32'd7, 1'b0), 64'h00000002_0000000E);
        chk("model_s1", model(32'hFFFF_FFF9, 32'd2, 1'b1), 64'hFFFFFFFF_FFFFFFFD);
        chk("model_s2", model(32'd7, 32'hFFFF_FFFE, 1'b1), 64'h00000001_FFFFFFFD);
        chk("model_ovf", model(32'h8000_0000, 32'hFFFF_FFFF, 1'b1), 64'h00000000_80000000);
        chk("model_dz", model(32'h1234_5678, 32'd0, 1'b0), 64'h12345678_FFFFFFFF);

        run("udiv", 32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 33);
        run("sdiv_neg", 32'hFFFF_FFF9, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 33);
        run("sdiv_negd", 32'd7, 32'hFFFF_FFFE, 1'b1, 64'h00000001_FFFFFFFD, 33);
        run("sdiv_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h00000000_80000000, 33);
        run("udz", 32'h1234_5678, 32'd0, 1'b0, 64'h12345678_FFFFFFFF, ZLAT);
        run("sdz", 32'h8000_0001, 32'd0, 1'b1, 64'h80000001_FFFFFFFF, ZLAT);
        run("ubig", 32'hFFFF_FFFF, 32'h10, 1'b0, 64'h0000000F_0FFFFFFF, 33);
        run("sdiv_nn", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 64'hFFFFFFFE_0000000E, 33);

        // Abort at iteration 10, then restart on the very next cycle.
        held = result;
        @(negedge clk); #1;
        opdata1 = 32'd1000; opdata2 = 32'd3; signed_div = 1'b0; start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        repeat (9) @(negedge clk);
        #1;
        chk("abort_busy_before", {63'd0, busy}, 64'd1);
        annul = 1'b1;
        @(negedge clk); #1;
        annul = 1'b0;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_ready", {63'd0, ready}, 64'd0);
        chk("abort_result", result, held);
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        n = 1;
        while (!ready && n < 80) begin
            @(negedge clk); #1;
            n++;
        end
        chk("restart_lat", 64'(n), 64'd33);
        chk("restart_res", result, 64'h00000001_0000014D);

        // Reset in the middle of an iteration sequence.
        @(negedge clk); #1;
        opdata1 = 32'd500; opdata2 = 32'd5; start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_ready", {63'd0, ready}, 64'd0);
        chk("midrst_result", result, 64'd0);
        @(negedge clk); #1;
        rst = 1'b0;
        run("after_rst", 32'd500, 32'd5, 1'b0, 64'h00000000_00000064, 33);

        // start held high through a divide, then accepted back-to-back after DONE.
        @(negedge clk); #1;
        opdata1 = 32'd81; opdata2 = 32'd9; signed_div = 1'b0; start = 1'b1;
        @(negedge clk); #1;
        n = 1;
        while (!ready && n < 80) begin
            @(negedge clk); #1;
            n++;
        end
        chk("hold_lat", 64'(n), 64'd33);
        chk("hold_res", result, 64'h00000000_00000009);
        opdata1 = 32'd50; opdata2 = 32'd8;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
            if (n == 2) start = 1'b0;
        end while (!ready && n < 80);
        chk("b2b_lat", 64'(n), 64'd34);
        chk("b2b_res", result, 64'h00000002_00000006);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule
